// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, the output pixel record and the output saturation
// helper used by the PE output path.
//   PE_RESULT_W / PE_BIAS_W / PE_OUT_W / PE_SHIFT_W : default datapath widths
//   PE_ACC_W  : width of the requantisation arithmetic. It is the stage-1 sum
//               plus one guard bit for the rounding constant.
//   OUT_MAX / OUT_MIN : saturation limits of a signed PE_OUT_W pixel
//   pixel_t   : {last, data} as stored in the output FIFO
//   sat_out() : clamps a PE_ACC_W signed value into the pixel range
package pe_pkg;

    localparam int PE_RESULT_W = 37;
    localparam int PE_BIAS_W   = 32;
    localparam int PE_OUT_W    = 16;
    localparam int PE_SHIFT_W  = 6;
    localparam int PE_ACC_W    = PE_RESULT_W + 3;

    localparam logic signed [PE_ACC_W-1:0] OUT_MAX = PE_ACC_W'((1 << (PE_OUT_W - 1)) - 1);
    localparam logic signed [PE_ACC_W-1:0] OUT_MIN = -OUT_MAX - PE_ACC_W'(1);

    typedef struct packed {
        logic                last;
        logic [PE_OUT_W-1:0] data;
    } pixel_t;

    function automatic logic [PE_OUT_W-1:0] sat_out(input logic signed [PE_ACC_W-1:0] v);
        logic [PE_OUT_W-1:0] r;
        if (v > OUT_MAX) begin
            r = OUT_MAX[PE_OUT_W-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[PE_OUT_W-1:0];
        end else begin
            r = v[PE_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// pe_out_fifo: first-word-fall-through pixel FIFO.
//   clk, rst_n       : clock and asynchronous active-low reset
//   push, wr_data    : write request and the pixel to write
//   pop              : read request. It is ignored while the FIFO is empty.
//   rd_data          : head pixel. It reads as zero while the FIFO is empty.
//   full, empty      : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// The write then lands in the slot that is being vacated.
module pe_out_fifo
    import pe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  pixel_t wr_data,
    input  logic   pop,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Zeroed head keeps out_data quiet when nothing is buffered. This covers
    // the state right after reset, because the storage itself is not reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pe_requant_out.sv
// pe_requant_out: requantises PE accumulator results into output pixels and
// streams them to the feature-map writer.
//   clk, rst_n            : clock and asynchronous active-low reset
//   result, valid         : PE result and its single-cycle qualifier. There is
//                           no backpressure.
//   cfg_bias/shift/relu   : quasi-static requantisation settings
//   out_data/last/valid   : ready/valid pixel stream. The FIFO head carries a
//                           row-end tag.
//   out_ready             : consumer accept
//   ovf, ovf_clr          : sticky drop flag and its clear
// Pipeline: stage 1 adds the bias. Stage 2 rounds, shifts, applies ReLU,
// saturates and tags the row end. The FIFO push follows one edge later.
module pe_requant_out
    import pe_pkg::*;
#(
    parameter int BIAS_W  = PE_BIAS_W,
    parameter int SHIFT_W = PE_SHIFT_W,
    parameter int DEPTH   = 4,
    parameter int IMG_W   = 28
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PE_RESULT_W-1:0] result,
    input  logic                   valid,
    input  logic [BIAS_W-1:0]      cfg_bias,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic                   cfg_relu,
    output logic [PE_OUT_W-1:0]    out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int RESULT_W = PE_RESULT_W;
    localparam int S1_W     = RESULT_W + 2;
    localparam int ACC_W    = PE_ACC_W;
    localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic signed [S1_W-1:0]  s1_reg;
    logic                    s1_vld_reg;
    pixel_t                  px_reg;
    pixel_t                  px_next;
    logic                    s2_vld_reg;
    logic [COL_W-1:0]        col_reg;
    logic                    ovf_reg;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] relu_val;

    pixel_t                  head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;

    // Stage 1: both operands are sign-extended into the wider sum domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= '0;
            s1_vld_reg <= 1'b0;
        end else begin
            s1_vld_reg <= valid;
            if (valid) begin
                s1_reg <= $signed({{2{result[RESULT_W-1]}}, result})
                        + $signed({{(S1_W-BIAS_W){cfg_bias[BIAS_W-1]}}, cfg_bias});
            end
        end
    end

    // Stage 2 arithmetic. One guard bit above S1_W absorbs the half-LSB
    // rounding constant, so round-half-up cannot wrap.
    always_comb begin
        acc = {s1_reg[S1_W-1], s1_reg};
        rnd = '0;
        if (cfg_shift != '0) begin
            rnd = ACC_W'(1) << (cfg_shift - SHIFT_W'(1));
        end
        shifted      = (acc + rnd) >>> cfg_shift;
        relu_val     = (cfg_relu && shifted[ACC_W-1]) ? '0 : shifted;
        px_next.data = sat_out(relu_val);
        px_next.last = (col_reg == COL_W'(IMG_W - 1));
    end

    // The column counter advances on every stage-2 pixel, even on pixels that
    // are dropped later, so row alignment survives FIFO overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_reg     <= '0;
            s2_vld_reg <= 1'b0;
            col_reg    <= '0;
        end else begin
            s2_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                px_reg  <= px_next;
                col_reg <= px_next.last ? '0 : col_reg + COL_W'(1);
            end
        end
    end

    assign pop  = out_valid && out_ready;
    assign drop = s2_vld_reg && fifo_full && !pop;

    // A new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    pe_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (s2_vld_reg),
        .wr_data (px_reg),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_last  = head.last;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pe_requant_out.sv
module tb_pe_requant_out;

    localparam int RESULT_W = 37;
    localparam int IMG_W    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [36:0]   result;
    logic          valid;
    logic [31:0]   cfg_bias;
    logic [5:0]    cfg_shift;
    logic          cfg_relu;
    logic [15:0]   out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          ovf;
    logic          ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_d[$];
    bit exp_l[$];

    always #5 clk = ~clk;

    pe_requant_out #(
        .IMG_W (IMG_W),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result    (result),
        .valid     (valid),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Called at a negedge. Holds reset for two cycles.
    task automatic do_reset();
        valid   = 1'b0;
        ovf_clr = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge. Presents one result for exactly one edge.
    task automatic send(input longint v);
        longint t;
        t      = v;
        result = t[RESULT_W-1:0];
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic exp_px(input int d, input bit l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    // Called at a negedge. Checks every accepted pixel against the queue.
    task automatic drain(input string tag, input int budget);
        int b;
        b = budget;
        while (exp_d.size() > 0 && b > 0) begin
            if (out_valid && out_ready) begin
                check({tag, "_data"}, longint'($signed(out_data)), longint'(exp_d.pop_front()));
                check({tag, "_last"}, longint'(out_last), longint'(exp_l.pop_front()));
            end
            @(negedge clk);
            b--;
        end
        if (exp_d.size() > 0) begin
            check({tag, "_timeout"}, longint'(exp_d.size()), 0);
            exp_d.delete();
            exp_l.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        result    = '0;
        valid     = 1'b0;
        cfg_bias  = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data",  longint'(out_data), 0);
        check("reset_out_last",  longint'(out_last), 0);
        check("reset_ovf",       longint'(ovf), 0);
        do_reset();

        // 1: latency and pass-through
        out_ready = 1'b1;
        result = 37'd8;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("t1_lat_e0", longint'(out_valid), 0);
        @(negedge clk);
        check("t1_lat_e1", longint'(out_valid), 0);
        @(negedge clk);
        check("t1_lat_e2", longint'(out_valid), 1);
        check("t1_data", longint'($signed(out_data)), 8);
        check("t1_last", longint'(out_last), 0);
        @(negedge clk);
        check("t1_popped", longint'(out_valid), 0);

        // 2: rounding shift
        do_reset();
        out_ready = 1'b0;
        cfg_shift = 6'd2;
        send(6); send(-6); send(5);
        exp_px(2, 0); exp_px(-1, 0); exp_px(1, 0);
        out_ready = 1'b1;
        drain("t2_rnd", 20);
        out_ready = 1'b0;
        cfg_bias  = 32'd4;
        send(0);
        exp_px(1, 0);
        out_ready = 1'b1;
        drain("t2_bias", 20);

        // 3: saturation and ReLU
        do_reset();
        out_ready = 1'b0;
        cfg_bias  = '0;
        cfg_shift = '0;
        send(longint'(1) <<< 20); send(-(longint'(1) <<< 20));
        exp_px(32767, 0); exp_px(-32768, 0);
        out_ready = 1'b1;
        drain("t3_sat", 20);
        out_ready = 1'b0;
        cfg_relu  = 1'b1;
        send(longint'(1) <<< 20); send(-(longint'(1) <<< 20));
        exp_px(32767, 0); exp_px(0, 0);
        out_ready = 1'b1;
        drain("t3_relu", 20);
        cfg_relu = 1'b0;

        // 4: overflow, ordering, clear, pop+push on full, set-beats-clear
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(i);
        repeat (4) @(negedge clk);
        check("t4_ovf_set", longint'(ovf), 1);
        check("t4_head", longint'($signed(out_data)), 1);
        repeat (3) @(negedge clk);
        check("t4_head_stable", longint'($signed(out_data)), 1);
        for (int i = 1; i <= 4; i++) exp_px(i, 0);
        out_ready = 1'b1;
        drain("t4_order", 20);
        check("t4_empty", longint'(out_valid), 0);
        check("t4_ovf_sticky", longint'(ovf), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", longint'(ovf), 0);
        out_ready = 1'b0;
        send(10); send(11); send(12); send(13);
        repeat (3) @(negedge clk);
        check("t4_refill_head", longint'($signed(out_data)), 10);
        send(14);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_popfull_ovf", longint'(ovf), 0);
        check("t4_popfull_head", longint'($signed(out_data)), 11);
        send(15);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_set_wins", longint'(ovf), 1);
        exp_px(11, 0); exp_px(12, 0); exp_px(13, 1); exp_px(14, 0);
        out_ready = 1'b1;
        drain("t4_after", 20);

        // 5: row tagging, then with drops
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) exp_px(i, (i == 5) || (i == 10));
        fork
            begin
                for (int i = 1; i <= 10; i++) send(i);
            end
            drain("t5_row", 40);
        join
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(i);
        repeat (3) @(negedge clk);
        check("t5_drop_ovf", longint'(ovf), 1);
        for (int i = 1; i <= 4; i++) exp_px(i, 0);
        out_ready = 1'b1;
        drain("t5_kept", 20);
        out_ready = 1'b0;
        send(8); send(9); send(10);
        exp_px(8, 0); exp_px(9, 0); exp_px(10, 1);
        out_ready = 1'b1;
        drain("t5_align", 20);

        // 6: asynchronous reset mid-operation
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(i);
        repeat (3) @(negedge clk);
        check("t6_pre_valid", longint'(out_valid), 1);
        check("t6_pre_ovf", longint'(ovf), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", longint'(out_valid), 0);
        check("t6_rst_ovf", longint'(ovf), 0);
        check("t6_rst_data", longint'(out_data), 0);
        check("t6_rst_last", longint'(out_last), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) exp_px(100 + i, i == 5);
        fork
            begin
                for (int i = 1; i <= 5; i++) send(100 + i);
            end
            drain("t6_restart", 30);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
